uart_alu_ctrl: RTL

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

---
 rtl/uart_alu_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_alu_ctrl.sv
// ============================================================================
// uart_alu_ctrl: collects A/B/opcode over UART, drives an external ALU and
// returns result, flags and status bytes.               Revision: 1.0
// ============================================================================
`default_nettype none

module uart_alu_ctrl #(
    parameter int         N           = 8,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0] STATUS_OK   = 8'h55,
    parameter logic [7:0] STATUS_ERR  = 8'hEE
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         rx_valid_i,
    input  logic [7:0]   rx_data_i,
    output logic         tx_start_o,
    output logic [7:0]   tx_data_o,
    input  logic         tx_done_i,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output logic [5:0]   alu_op_o,
    input  logic [N-1:0] alu_result_i,
    input  logic [2:0]   alu_flags_i,
    output logic         busy_o,
    output logic [7:0]   err_count_o
);

    localparam int NB = N / 8;
    localparam int CW = $clog2(NB) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [3:0] {
        S_IDLE, S_RX_A, S_RX_B, S_RX_OP, S_EXEC,
        S_TX_RES, S_TX_FLG, S_TX_STA, S_TX_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [N-1:0]    sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [N-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [5:0]      alu_op_q, alu_op_d;
    logic [N-1:0]    res_q, res_d;
    logic [2:0]      flg_q, flg_d;
    logic            wait_q, wait_d;
    logic [7:0]      err_q, err_d;

    logic            w_rx_state, w_tx_state, w_tmo_exp, w_last, w_adv;

    assign w_rx_state = state_q inside {S_RX_A, S_RX_B, S_RX_OP};
    assign w_tx_state = state_q inside {S_TX_RES, S_TX_FLG, S_TX_STA, S_TX_ERR};
    assign w_tmo_exp  = (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign w_last     = (cnt_q == CW'(NB - 1));
    assign w_adv      = wait_q && tx_done_i;

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign busy_o      = (state_q != S_IDLE);
    assign err_count_o = err_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tmo_q    <= '0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            res_q    <= '0;
            flg_q    <= '0;
            wait_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            res_q    <= res_d;
            flg_q    <= flg_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        sh_a_d     = sh_a_q;
        sh_b_d     = sh_b_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        res_d      = res_q;
        flg_d      = flg_q;
        wait_d     = wait_q;
        err_d      = err_q;
        tx_start_o = 1'b0;
        tx_data_o  = 8'h00;

        // wait_q marks a byte handed to the transmitter; tx_done is only honoured then
        if (w_tx_state) begin
            if (!wait_q) begin
                tx_start_o = 1'b1;
                wait_d     = 1'b1;
            end else if (tx_done_i) begin
                wait_d = 1'b0;
            end
        end

        // An arriving byte always wins over an expiring timeout
        if (w_rx_state && !rx_valid_i) begin
            if (w_tmo_exp) begin
                state_d = S_TX_ERR;
                cnt_d   = '0;
                tmo_d   = '0;
                err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    sh_a_d[7:0] = rx_data_i;
                    tmo_d       = '0;
                    if (NB == 1) begin
                        state_d = S_RX_B;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_RX_A;
                        cnt_d   = CW'(1);
                    end
                end
            end
            S_RX_A, S_RX_B: begin
                if (rx_valid_i) begin
                    for (int i = 0; i < NB; i++) begin
                        if (cnt_q == CW'(i)) begin
                            if (state_q == S_RX_A) sh_a_d[8*i +: 8] = rx_data_i;
                            else                   sh_b_d[8*i +: 8] = rx_data_i;
                        end
                    end
                    tmo_d = '0;
                    if (w_last) begin
                        state_d = (state_q == S_RX_A) ? S_RX_B : S_RX_OP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_RX_OP: begin
                // Commit here so the ALU sees the new operands throughout EXEC
                if (rx_valid_i) begin
                    alu_a_d  = sh_a_q;
                    alu_b_d  = sh_b_q;
                    alu_op_d = rx_data_i[5:0];
                    tmo_d    = '0;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = alu_result_i;
                flg_d   = alu_flags_i;
                cnt_d   = '0;
                state_d = S_TX_RES;
            end
            S_TX_RES: begin
                tx_data_o = 8'(res_q >> {cnt_q, 3'b000});
                if (w_adv) begin
                    if (w_last) begin
                        state_d = S_TX_FLG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_TX_FLG: begin
                tx_data_o = {flg_q, 5'b00000};
                if (w_adv) state_d = S_TX_STA;
            end
            S_TX_STA: begin
                tx_data_o = STATUS_OK;
                if (w_adv) state_d = S_IDLE;
            end
            S_TX_ERR: begin
                tx_data_o = STATUS_ERR;
                if (w_adv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire
